ram32_byte_ctrl: RTL and testbench

- Byte-serial host front end that sits directly upstream of the 32x32 RAM macro and drives its port A: CLK, per-byte write enables, enable, 5-bit address and 32-bit write data; it consumes the 32-bit read data.
- Converts an 8-bit valid/ready command/data stream into single-cycle RAM accesses.
- Serialises read words back out as 4 bytes.
- Lets the 8-bit-pin top level load and dump the RAM.

---
 rtl/ram32_byte_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_ram32_byte_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram32_byte_ctrl.sv
// Byte-serial command/data front end driving port A of a 32x32 RAM macro.
// Define RAM32_BYTE_MASK_EN to insert a per-write byte-mask byte (state WMASK).
module ram32_byte_ctrl #(
  parameter int LSB_FIRST    = 1,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [4:0]  ram_addr,
  output logic [31:0] ram_di,
  input  logic [31:0] ram_do
);

  localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WMASK  = 3'd1,
    S_WDATA  = 3'd2,
    S_WRITE  = 3'd3,
    S_RD_REQ = 3'd4,
    S_RD_CAP = 3'd5,
    S_RD_OUT = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [3:0]      mask_q, mask_d;
  logic [4:0]      addr_q, addr_d;
  logic [31:0]     di_q, di_d;
  logic [31:0]     sr_q, sr_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            ram_en_q, ram_en_d;
  logic [3:0]      ram_we_q, ram_we_d;

  logic            in_xfer_s;
  logic            out_xfer_s;
  logic            tmo_hit_s;
  logic [TW-1:0]   tmo_inc_s;
  logic            unused_cmd_bits_s;

  assign in_xfer_s         = in_valid & in_ready_q;
  assign out_xfer_s        = out_valid_q & out_ready;
  assign unused_cmd_bits_s = ^in_data[6:5];

  // Idle-timeout terminal count and increment; constant zero when disabled.
  always_comb begin
    if (IDLE_TIMEOUT > 0) begin
      tmo_hit_s = (tmo_q == TW'(IDLE_TIMEOUT - 1));
      tmo_inc_s = tmo_q + TW'(1);
    end else begin
      tmo_hit_s = 1'b0;
      tmo_inc_s = {TW{1'b0}};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    tmo_d   = tmo_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    di_d    = di_q;
    sr_d    = sr_q;

    case (state_q)
      S_IDLE: begin
        tmo_d = {TW{1'b0}};
        if (in_xfer_s) begin
          addr_d = in_data[4:0];
          bcnt_d = 2'd0;
          if (in_data[7]) begin
`ifdef RAM32_BYTE_MASK_EN
            state_d = S_WMASK;
`else
            mask_d  = 4'hF;
            state_d = S_WDATA;
`endif
          end else begin
            state_d = S_RD_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WMASK: begin
`ifdef RAM32_BYTE_MASK_EN
        if (in_xfer_s) begin
          mask_d  = in_data[3:0];
          tmo_d   = {TW{1'b0}};
          state_d = S_WDATA;
        end else if (tmo_hit_s) begin
          tmo_d   = {TW{1'b0}};
          state_d = S_IDLE;
        end else begin
          tmo_d   = tmo_inc_s;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_WDATA: begin
        if (in_xfer_s) begin
          if (LSB_FIRST != 0) begin
            di_d = {in_data, di_q[31:8]};
          end else begin
            di_d = {di_q[23:0], in_data};
          end
          bcnt_d = bcnt_q + 2'd1;
          tmo_d  = {TW{1'b0}};
          if (bcnt_q == 2'd3) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_WDATA;
          end
        end else if (tmo_hit_s) begin
          tmo_d   = {TW{1'b0}};
          state_d = S_IDLE;
        end else begin
          tmo_d   = tmo_inc_s;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_RD_REQ: begin
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        sr_d    = ram_do;
        bcnt_d  = 2'd0;
        state_d = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (out_xfer_s) begin
          if (LSB_FIRST != 0) begin
            sr_d = {8'h00, sr_q[31:8]};
          end else begin
            sr_d = {sr_q[23:0], 8'h00};
          end
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RD_OUT;
          end
        end else begin
          state_d = S_RD_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state will present.
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_WMASK) || (state_d == S_WDATA);
    busy_d      = (state_d != S_IDLE);
    ram_en_d    = (state_d == S_WRITE) || (state_d == S_RD_REQ);
    ram_we_d    = (state_d == S_WRITE) ? mask_d : 4'h0;
    out_valid_d = (state_d == S_RD_OUT);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      bcnt_q      <= 2'd0;
      tmo_q       <= {TW{1'b0}};
      mask_q      <= 4'h0;
      addr_q      <= 5'd0;
      di_q        <= 32'h0000_0000;
      sr_q        <= 32'h0000_0000;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      tmo_q       <= tmo_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      di_q        <= di_d;
      sr_q        <= sr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = (LSB_FIRST != 0) ? sr_q[7:0] : sr_q[31:24];
  assign busy      = busy_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q;
  assign ram_di    = di_q;

endmodule

// File: tb/tb_ram32_byte_ctrl.sv
// Directed bench: three controllers (default, MSB-first, idle timeout 8), each on its own RAM model.
module tb_ram32_byte_ctrl;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  in_data_a   [3];
  logic        in_valid_a  [3];
  logic        in_ready_a  [3];
  logic [7:0]  out_data_a  [3];
  logic        out_valid_a [3];
  logic        out_ready_a [3];
  logic        busy_a      [3];
  logic        ram_en_a    [3];
  logic [3:0]  ram_we_a    [3];
  logic [4:0]  ram_addr_a  [3];
  logic [31:0] ram_di_a    [3];
  logic [31:0] ram_do_a    [3];

  int checks = 0;
  int errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] mem [32];
    logic [31:0] rdo;
    int          en_cnt = 0;

    ram32_byte_ctrl #(
      .LSB_FIRST   ((g == 1) ? 0 : 1),
      .IDLE_TIMEOUT((g == 2) ? 8 : 0)
    ) u_dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .in_data  (in_data_a[g]),
      .in_valid (in_valid_a[g]),
      .in_ready (in_ready_a[g]),
      .out_data (out_data_a[g]),
      .out_valid(out_valid_a[g]),
      .out_ready(out_ready_a[g]),
      .busy     (busy_a[g]),
      .ram_en   (ram_en_a[g]),
      .ram_we   (ram_we_a[g]),
      .ram_addr (ram_addr_a[g]),
      .ram_di   (ram_di_a[g]),
      .ram_do   (rdo)
    );

    assign ram_do_a[g] = rdo;

    // RAM macro model: byte write enables, registered read, Do forced to 0 when disabled.
    always @(posedge CLK) begin
      if (ram_en_a[g]) begin
        rdo    <= mem[ram_addr_a[g]];
        en_cnt <= en_cnt + 1;
        for (int b = 0; b < 4; b++) begin
          if (ram_we_a[g][b]) mem[ram_addr_a[g]][8*b +: 8] <= ram_di_a[g][8*b +: 8];
        end
      end else begin
        rdo <= 32'h0000_0000;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input int i, input logic [7:0] b, input string tag);
    int n;
    in_data_a[i]  = b;
    in_valid_a[i] = 1'b1;
    n = 0;
    while (in_ready_a[i] !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_rdy"}, 32'(in_ready_a[i]), 32'h1);
    @(posedge CLK);
    #1;
    in_valid_a[i] = 1'b0;
    in_data_a[i]  = 8'h00;
  endtask

  task automatic write_word(input int i, input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] mask, input bit lsb, input string tag);
    logic [3:0] exp_we;
    send_byte(i, {3'b100, addr}, {tag, "_cmd"});
`ifdef RAM32_BYTE_MASK_EN
    send_byte(i, {4'h0, mask}, {tag, "_mask"});
    exp_we = mask;
`else
    exp_we = 4'hF;
`endif
    for (int k = 0; k < 4; k++) begin
      send_byte(i, lsb ? data[8*k +: 8] : data[24-8*k +: 8], {tag, "_dat"});
    end
    chk({tag, "_en"},   32'(ram_en_a[i]),   32'h1);
    chk({tag, "_we"},   32'(ram_we_a[i]),   32'(exp_we));
    chk({tag, "_addr"}, 32'(ram_addr_a[i]), 32'(addr));
    chk({tag, "_di"},   ram_di_a[i],        data);
    @(posedge CLK);
    #1;
    chk({tag, "_en_off"}, 32'(ram_en_a[i]), 32'h0);
    chk({tag, "_we_off"}, 32'(ram_we_a[i]), 32'h0);
  endtask

  task automatic recv_word(input int i, input logic [31:0] exp, input bit lsb, input string tag);
    int n;
    logic [7:0] eb;
    out_ready_a[i] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (out_valid_a[i] !== 1'b1 && n < 50) begin
        @(negedge CLK);
        n++;
      end
      eb = lsb ? exp[8*k +: 8] : exp[24-8*k +: 8];
      chk($sformatf("%s_vld%0d", tag, k), 32'(out_valid_a[i]), 32'h1);
      chk($sformatf("%s_byte%0d", tag, k), 32'(out_data_a[i]), 32'(eb));
      @(posedge CLK);
      #1;
    end
    out_ready_a[i] = 1'b0;
    chk({tag, "_vld_end"},  32'(out_valid_a[i]), 32'h0);
    chk({tag, "_busy_end"}, 32'(busy_a[i]),      32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int         en_snap;
    logic [6:0] pat;
    logic [31:0] bp_word;
    int         nb;

    RST_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data_a[i]   = 8'h00;
      in_valid_a[i]  = 1'b0;
      out_ready_a[i] = 1'b0;
    end

    // Reset state
    #12;
    chk("rst_in_ready",  32'(in_ready_a[0]),  32'h0);
    chk("rst_busy",      32'(busy_a[0]),      32'h0);
    chk("rst_ram_en",    32'(ram_en_a[0]),    32'h0);
    chk("rst_out_valid", 32'(out_valid_a[0]), 32'h0);
    chk("rst_ram_di",    ram_di_a[0],         32'h0);
    #11;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("rel_in_ready", 32'(in_ready_a[0]), 32'h1);
    chk("rel_busy",     32'(busy_a[0]),     32'h0);

    // Reset mid-write discards the transaction
    send_byte(0, 8'h83, "mw_cmd");
`ifdef RAM32_BYTE_MASK_EN
    send_byte(0, 8'h0F, "mw_mask");
`endif
    send_byte(0, 8'h11, "mw_d0");
    send_byte(0, 8'h22, "mw_d1");
    chk("mw_busy_pre", 32'(busy_a[0]), 32'h1);
    en_snap = g_dut[0].en_cnt;
    #2;
    RST_N = 1'b0;
    #1;
    chk("mw_async_in_ready", 32'(in_ready_a[0]), 32'h0);
    chk("mw_async_busy",     32'(busy_a[0]),     32'h0);
    chk("mw_async_addr",     32'(ram_addr_a[0]), 32'h0);
    chk("mw_async_di",       ram_di_a[0],        32'h0);
    repeat (2) @(posedge CLK);
    #3;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("mw_rel_in_ready", 32'(in_ready_a[0]), 32'h1);
    chk("mw_rel_busy",     32'(busy_a[0]),     32'h0);
    repeat (6) @(posedge CLK);
    #1;
    chk("mw_no_ram_en", 32'(g_dut[0].en_cnt), 32'(en_snap));

    // Write then read, LSB first, with read latency
    write_word(0, 5'd5, 32'h1234_5678, 4'hF, 1'b1, "wr5");
    send_byte(0, 8'h05, "rd5_cmd");
    chk("rd5_en",   32'(ram_en_a[0]),    32'h1);
    chk("rd5_we",   32'(ram_we_a[0]),    32'h0);
    chk("rd5_lat1", 32'(out_valid_a[0]), 32'h0);
    @(posedge CLK);
    #1;
    chk("rd5_lat2",   32'(out_valid_a[0]), 32'h0);
    chk("rd5_en_off", 32'(ram_en_a[0]),    32'h0);
    @(posedge CLK);
    #1;
    chk("rd5_lat3", 32'(out_valid_a[0]), 32'h1);
    recv_word(0, 32'h1234_5678, 1'b1, "rd5");
    chk("rd5_addr_hold", 32'(ram_addr_a[0]), 32'h5);
    chk("rd5_di_hold",   ram_di_a[0],        32'h1234_5678);

    // Output backpressure on address 31
    write_word(0, 5'd31, 32'hDEAD_BEEF, 4'hF, 1'b1, "wr31");
    send_byte(0, 8'h1F, "rd31_cmd");
    repeat (2) @(posedge CLK);
    #1;
    pat     = 7'b1011001;
    bp_word = 32'hDEAD_BEEF;
    nb      = 0;
    for (int k = 0; k < 7; k++) begin
      out_ready_a[0] = pat[k];
      chk($sformatf("bp_vld%0d", k),  32'(out_valid_a[0]), 32'h1);
      chk($sformatf("bp_data%0d", k), 32'(out_data_a[0]),  32'(bp_word[8*nb +: 8]));
      @(posedge CLK);
      #1;
      if (pat[k]) nb++;
    end
    out_ready_a[0] = 1'b0;
    chk("bp_vld_end",  32'(out_valid_a[0]), 32'h0);
    chk("bp_busy_end", 32'(busy_a[0]),      32'h0);
    @(posedge CLK);
    #1;
    chk("bp_vld_after", 32'(out_valid_a[0]), 32'h0);

    // MSB-first instance
    write_word(1, 5'd0, 32'hAABB_CCDD, 4'hF, 1'b0, "msb_wr");
    send_byte(1, 8'h00, "msb_rd_cmd");
    recv_word(1, 32'hAABB_CCDD, 1'b0, "msb_rd");

    // Idle timeout aborts a partial write
    write_word(2, 5'd1, 32'hCAFE_F00D, 4'hF, 1'b1, "to_pre");
    send_byte(2, 8'h81, "to_cmd");
    send_byte(2, 8'h01, "to_b1");
    en_snap = g_dut[2].en_cnt;
    repeat (4) @(posedge CLK);
    #1;
    chk("to_busy_mid", 32'(busy_a[2]), 32'h1);
    repeat (6) @(posedge CLK);
    #1;
    chk("to_busy_end",     32'(busy_a[2]),     32'h0);
    chk("to_in_ready_end", 32'(in_ready_a[2]), 32'h1);
    chk("to_no_ram_en",    32'(g_dut[2].en_cnt), 32'(en_snap));
    send_byte(2, 8'h01, "to_rd_cmd");
    recv_word(2, 32'hCAFE_F00D, 1'b1, "to_rd");

`ifdef RAM32_BYTE_MASK_EN
    // Partial-byte write through the mask
    write_word(0, 5'd2, 32'hFFFF_FFFF, 4'hF, 1'b1, "mk_pre");
    write_word(0, 5'd2, 32'h0000_0000, 4'h5, 1'b1, "mk_wr");
    send_byte(0, 8'h02, "mk_rd_cmd");
    recv_word(0, 32'hFF00_FF00, 1'b1, "mk_rd");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
